// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), one bit per cycle.
// Valid/ready on both sides; result registers hold until the next completion.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [BW-1:0]   res_q, res_d;
  logic [BW-1:0]   adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            ovfo_q, ovfo_d;
  logic            last;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k+:4] >= 4'd5) begin
        adj[4*k+:4] = bcd_q[4*k+:4] + 4'd3;
      end
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ovfo_d  = ovfo_q;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          bin_d   = in_bin;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // the bit pushed out of the top digit means the value is too large
        bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        ovf_d = ovf_q | adj[BW-1];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          res_d   = bcd_d;
          ovfo_d  = ovf_d;
          state_d = DONE;
        end
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign out_bcd  = res_q;
  assign overflow = ovfo_q;

endmodule
